// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between the binary source, bin2bcd_seq and the
// seven-segment multiplexer.
interface bin2bcd_seq_if;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  bcd3;
    logic [3:0]  bcd2;
    logic [3:0]  bcd1;
    logic [3:0]  bcd0;

    modport master (
        output start, bin,
        input  busy, done, ovf, bcd3, bcd2, bcd1, bcd0
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, bcd3, bcd2, bcd1, bcd0
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per clock).
// Optional macro BIN2BCD_SATURATE_EN: out-of-range inputs display 9999 instead of bin mod 10000.
module bin2bcd_seq (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [33:0] sreg_q, sreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [15:0] bcd_q, bcd_d;

    // Five BCD nibbles sit above the 14 binary bits: [33:30] is ten-thousands.
    logic [19:0] adj;
    logic [33:0] shifted;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_add3
            assign adj[gi*4 +: 4] = (sreg_q[14 + gi*4 +: 4] >= 4'd5)
                                  ? sreg_q[14 + gi*4 +: 4] + 4'd3
                                  : sreg_q[14 + gi*4 +: 4];
        end
    endgenerate

    assign shifted = {adj[18:0], sreg_q[13:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d  = {20'b0, bus.bin};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                sreg_d = shifted;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = (shifted[33:30] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
                    bcd_d   = (shifted[33:30] != 4'd0) ? 16'h9999 : shifted[29:14];
`else
                    bcd_d   = shifted[29:14];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.bcd3 = bcd_q[15:12];
    assign bus.bcd2 = bcd_q[11:8];
    assign bus.bcd1 = bcd_q[7:4];
    assign bus.bcd0 = bcd_q[3:0];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, handshake corner cases and
// a randomised scoreboard run against a decimal reference model.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2bcd_seq_if bus ();
    bin2bcd_seq dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] bin;
        logic [16:0] exp;   // {ovf, d3, d2, d1, d0}
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [13:0] bin;
        logic [16:0] exp;
    } vec_t;
    vec_t vecs [8];

    int          done_count    = 0;
    int          cyc           = 0;
    int          last_done_cyc = 0;
    int          prev_done_cyc = 0;
    logic        done_prev     = 1'b0;
    logic [16:0] last_exp      = '0;

    logic [16:0] outs_w;
    logic [18:0] state_w;
    assign outs_w  = {bus.ovf, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    assign state_w = {bus.busy, bus.done, outs_w};

    function automatic logic [16:0] model(input logic [13:0] v);
        int n, m;
        logic [3:0] d3, d2, d1, d0;
        n  = int'(v);
        m  = n % 10000;
        d3 = 4'(m / 1000);
        d2 = 4'((m / 100) % 10);
        d1 = 4'((m / 10) % 10);
        d0 = 4'(m % 10);
`ifdef BIN2BCD_SATURATE_EN
        if (n > 9999) return {1'b1, 16'h9999};
`endif
        return {(n > 9999), d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Acceptance happens whenever start is seen while the converter is idle.
    initial begin
        forever begin
            @(posedge clk);
            if (reset && bus.start && !bus.busy)
                sb.push_back('{bus.bin, model(bus.bin)});
        end
    end

    // Scoreboard consumer: one line per completed conversion.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset && bus.done) begin
                done_count++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                check("done_busy_overlap", {31'b0, bus.busy}, 32'd0);
                check("done_width", {31'b0, done_prev}, 32'd0);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=%0h required=none", outs_w);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    $display("conv bin=%0d got=%05h exp=%05h", e.bin, outs_w, e.exp);
                    if (outs_w !== e.exp) begin
                        errors++;
                        $display("FAIL scoreboard bin=%0d actual=%05h required=%05h",
                                 e.bin, outs_w, e.exp);
                    end
                    last_exp = e.exp;
                end
            end
            done_prev = reset && bus.done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic run_one(input logic [13:0] v, output int busy_n, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bin   = 14'($urandom);
        busy_n = 0;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
        end while (!bus.done && lat < 40);
        // done is observed in the 15th cycle after the accepting edge
        check("latency", lat, 32'd15);
    endtask

    initial begin
        int bn, lt, dc0, gap;
        logic [13:0] v;

        vecs[0] = '{14'd0,     17'h00000};
        vecs[1] = '{14'd1234,  17'h01234};
        vecs[2] = '{14'd9999,  17'h09999};
`ifdef BIN2BCD_SATURATE_EN
        vecs[3] = '{14'd10000, 17'h19999};
        vecs[4] = '{14'd16383, 17'h19999};
`else
        vecs[3] = '{14'd10000, 17'h10000};
        vecs[4] = '{14'd16383, 17'h16383};
`endif
        vecs[5] = '{14'd5,     17'h00005};
        vecs[6] = '{14'd4095,  17'h04095};
        vecs[7] = '{14'd8000,  17'h08000};

        bus.start = 1'b0;
        bus.bin   = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {13'b0, state_w}, 32'd0);
        #2 reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].bin, bn, lt);
            check("busy_cycles", bn, 32'd14);
            check("vector", {15'b0, outs_w}, {15'b0, vecs[i].exp});
        end
        repeat (5) @(negedge clk);
        check("hold_after_vectors", {14'b0, bus.done, outs_w}, {15'b0, vecs[7].exp});

        // start during CONV is ignored and produces no extra done
        dc0 = done_count;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd1234;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        check("ignored_start_dones", done_count - dc0, 32'd1);
        check("ignored_start_value", {15'b0, outs_w}, 32'h01234);

        // start held high: back-to-back conversions
        @(negedge clk);
        dc0 = done_count;
        bus.start = 1'b1;
        bus.bin   = 14'd42;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_count >= dc0 + 3) break;
        end
        check("b2b_done_count", {31'b0, (done_count >= dc0 + 3)}, 32'd1);
        check("b2b_period", last_done_cyc - prev_done_cyc, 32'd15);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("b2b_value", {15'b0, outs_w}, 32'h00042);
        check("b2b_drained", sb.size(), 32'd0);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 14'd9876;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midconv_reset", {13'b0, state_w}, 32'd0);
        sb.delete();
        dc0 = done_count;
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", done_count - dc0, 32'd0);
        run_one(14'd321, bn, lt);
        check("post_reset_busy", bn, 32'd14);
        check("post_reset_value", {15'b0, outs_w}, 32'h00321);

        for (int r = 0; r < 1000; r++) begin
            gap = $urandom_range(0, 2);
            repeat (gap + 1) @(negedge clk);
            check("hold", {14'b0, bus.done, outs_w}, {15'b0, last_exp});
            v = 14'($urandom_range(0, 16383));
            run_one(v, bn, lt);
            check("rand_busy", bn, 32'd14);
        end
        repeat (3) @(negedge clk);
        check("final_drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment multiplexer. It accepts a 14-bit unsigned binary value on a start/busy/done handshake, converts it with iterative shift-and-add-3 (double dabble), one bit per clock, and presents four registered BCD digits that wire straight to the multiplexer's `hex3..hex0` inputs. Outputs hold the last completed result, so the display never shows intermediate values.

## Interface
- `W`, 14: binary input width. Fixed at 14; other values are unsupported.
- `clk`  input  1  system clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  request conversion of `bin`; sampled only in IDLE
- `bin`  input  14  unsigned value; captured on the accepting edge
- `busy`  output  1  high while a conversion is in progress
- `done`  output  1  one-cycle pulse when new digits are valid
- `ovf`  output  1  captured `bin` was > 9999; updated with the digits
- `bcd3`  output  4  thousands digit, to `hex3`
- `bcd2`  output  4  hundreds digit, to `hex2`
- `bcd1`  output  4  tens digit, to `hex1`
- `bcd0`  output  4  units digit, to `hex0`

## Operation
- States: IDLE, CONV.
- IDLE + `start`=1:
  - load shift register {20'b0, `bin`};
  - clear the 4-bit iteration counter;
  - go to CONV.
- IDLE + `start`=0: hold.
- CONV, each cycle:
  - for each of the 5 BCD nibbles (ten-thousands..units) holding ≥5, add 3;
  - then shift the 34-bit register left by 1;
  - increment the counter.
- After iteration 14 (counter = 13 on that edge), on the same edge:
  - load `bcd3..bcd0` from the low 16 BCD bits;
  - compute `ovf` (ten-thousands nibble ≠ 0);
  - set `done`=1 and return to IDLE.
- `start` in CONV is ignored. It is not queued and `bin` is not re-sampled.
- `start` held high continuously: a new conversion begins on each edge where the state is IDLE. This gives back-to-back conversions with a 15-cycle period.
- `bin` may change freely after the accepting edge.
- Arithmetic:
  - add-3 applies per nibble on 4 bits; no carry between nibbles.
  - the ten-thousands nibble never exceeds 1 for 14-bit input.
- Reset (asserted at any time, including mid-CONV) forces:
  - state IDLE;
  - `busy`=0, `done`=0, `ovf`=0, `bcd3..bcd0`=0;
  - shift register and counter cleared.
- A conversion interrupted by reset is discarded and not resumed.

## Timing
- Accepting edge E0 (IDLE, `start`=1). `busy` is high from after E0 through E14, then low after E14: 14 cycles total.
- Iterations occur on E1..E14.
- Digits, `ovf` and `done` update on E14. `done` is high for exactly the cycle after E14.
- Start-to-result latency is 14 cycles. The minimum interval between accepting edges is 15 cycles, because E15 is the next acceptable edge.
- `done` and `busy` are never high together.
- `busy` is a registered output; it is not decoded combinationally from `start`.
- Outputs between `done` pulses are stable and equal to the last result.
- Deassertion of `reset` is asynchronous to `clk`. The first edge after deassertion may accept `start`.

## Configuration
- `BIN2BCD_SATURATE_EN`
  - Defined: when the ten-thousands nibble ≠ 0 at completion, `bcd3..bcd0` load 9,9,9,9 and `ovf`=1.
  - Undefined: the digits always load the low four BCD digits, i.e. `bin` mod 10000; `ovf` still flags > 9999.
- In-range behaviour is identical in both builds.

## Test plan
- Reset then `bin`=0, `start` pulse → `done` after 14 cycles; digits 0,0,0,0; `ovf`=0.
- `bin`=1234 → digits 1,2,3,4. `bin`=9999 → digits 9,9,9,9; `ovf`=0. Check `busy` is high exactly 14 cycles and `done` is high exactly 1 cycle.
- `bin`=10000 and `bin`=16383:
  - without macro → 0,0,0,0 / 6,3,8,3 with `ovf`=1;
  - with macro → 9,9,9,9 / 9,9,9,9 with `ovf`=1.
- Start 1234, then pulse `start` with `bin`=5678 at cycle 5 of CONV → result 1,2,3,4; only one `done`. Then hold `start` high with `bin`=42 → `done` every 15 cycles; digits 0,0,4,2.
- Start 9876, then assert `reset` at cycle 7 → all outputs 0 immediately. No `done` appears. After release, start 321 → 0,3,2,1 in 14 cycles.
- 1000 random `bin` in 0..16383 versus a reference model for both macro settings. Verify outputs hold between conversions.
